// File: rtl/one_four_demux.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a single-entry output buffer.
// Optional per-channel delivery counters (ch_cnt) are enabled by defining ONE_FOUR_DEMUX_CNT_EN.
module one_four_demux #(
  parameter int         WIDTH  = 8,
  parameter logic [3:0] CH_EN  = 4'b1111,
  parameter int         DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  i,
  input  logic [1:0]        s,
  input  logic              i_valid,
  output logic              i_ready,
  output logic [WIDTH-1:0]  y,
  output logic [3:0]        y_valid,
  input  logic [3:0]        y_ready,
  output logic [DROP_W-1:0] drop_cnt
`ifdef ONE_FOUR_DEMUX_CNT_EN
  ,
  output logic [4*16-1:0]   ch_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state;
  logic [1:0] held_sel;
  logic       full;
  logic       drain;
  logic       accept;
  logic       ch_ok;

  assign full    = (state == FULL);
  assign drain   = full & y_ready[held_sel];
  // Ready looks only at the buffer and the owning consumer, never at i_valid or s.
  assign i_ready = ~full | drain;
  assign accept  = i_valid & i_ready;
  assign ch_ok   = CH_EN[s];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      held_sel <= 2'd0;
      y        <= '0;
      y_valid  <= 4'b0000;
      drop_cnt <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept && ch_ok) begin
            y        <= i;
            held_sel <= s;
            y_valid  <= 4'b0001 << s;
            state    <= FULL;
          end
        end
        FULL: begin
          if (accept && ch_ok) begin
            y        <= i;
            held_sel <= s;
            y_valid  <= 4'b0001 << s;
            state    <= FULL;
          end else if (drain) begin
            y_valid  <= 4'b0000;
            state    <= EMPTY;
          end
        end
        default: begin
          y_valid <= 4'b0000;
          state   <= EMPTY;
        end
      endcase
      // Dropped beats are consumed without touching the buffer; the count sticks at all-ones.
      if (accept && !ch_ok && (drop_cnt != {DROP_W{1'b1}}))
        drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

`ifdef ONE_FOUR_DEMUX_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (drain && (held_sel == 2'(k)))
          ch_cnt[16*k +: 16] <= ch_cnt[16*k +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/one_four_demux.md
Name: one_four_demux

Overview:
- Registered 1-to-4 stream demultiplexer: the distribution counterpart of the team's 4:1 / 2:1 selector muxes.
- Takes a single valid/ready input stream with a 2-bit channel select per beat. Delivers each beat to exactly one of four valid/ready output channels through a single-entry output buffer.
- Sits between a shared producer and four per-channel consumers.
- Beats addressed to disabled channels are discarded and counted.

Parameters:
- WIDTH, 8, data width of every beat.
- CH_EN, 4'b1111, channel-enable mask; bit k=1 means channel k exists; beats to a channel with bit=0 are dropped.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i  input  WIDTH  input beat data.
- s  input  2  destination channel of the input beat.
- i_valid  input  1  input beat present.
- i_ready  output  1  block can accept the input beat this cycle.
- y  output  WIDTH  buffered beat data, shared by all four channels.
- y_valid  output  4  one-hot; bit k=1 means channel k owns the beat on y.
- y_ready  input  4  per-channel consumer ready.
- drop_cnt  output  DROP_W  count of beats dropped to disabled channels (saturating).

Behaviour:
- State:
  - full flag (0 = EMPTY, 1 = FULL).
  - held_sel[1:0].
  - data register.
  - drop counter.
- Reset, asynchronous, while rst=1:
  - full=0, held_sel=0, y=0, y_valid=4'b0000, drop_cnt=0.
  - Any buffered beat is lost.
  - i_ready=1 (EMPTY) once rst deasserts.
- Output decode:
  - y_valid = full ? (4'b0001 << held_sel) : 4'b0000.
  - y is the register contents, unchanged while held.
- Drain condition: drain = full & y_ready[held_sel]. y_ready bits of non-owning channels are ignored.
- Accept condition:
  - i_ready = ~full | drain.
  - accept = i_valid & i_ready.
  - i_ready is combinational from y_ready; it must not depend on i_valid or s.
- On accept with CH_EN[s]=1:
  - Data register <= i, held_sel <= s, full <= 1 next cycle.
  - Latency is 1 cycle from accept to y_valid.
- On accept with CH_EN[s]=0:
  - Beat is consumed but not stored.
  - drop_cnt increments by 1 and saturates at all-ones; it never wraps.
  - full becomes (full & ~drain).
- Simultaneous drain and accept to an enabled channel: buffer reloads in the same edge and full stays 1. Back-to-back throughput is 1 beat/cycle, including a change of destination channel.
- Drain without accept: full <= 0.
- Neither: state holds; y, held_sel and y_valid are stable while full & ~y_ready[held_sel].
- FSM, two states:
  - EMPTY -> FULL on accept to an enabled channel.
  - FULL -> EMPTY on drain with no enabled accept.
  - FULL -> FULL otherwise while full.
- s is sampled only on accept cycles; s changes while i_valid=0 have no effect.
- A beat is never duplicated and never appears on two channels. y_valid has at most one bit set.

Optional Feature:
- Macro: ONE_FOUR_DEMUX_CNT_EN.
- Defined:
  - Adds output port ch_cnt, width 4*16.
  - Holds four 16-bit wrapping counters; slice k increments on every drain of channel k.
  - All counters reset to 0 by rst.
  - A drain and an accept in the same cycle counts only the drain.
- Not defined:
  - Port ch_cnt and its counters are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-transfer with full=1 -> y_valid=0000, y=0, drop_cnt=0, i_ready=1 immediately, without a clock edge.
- Basic routing: i=8'hA5, s=2, i_valid=1, all y_ready=1 -> next cycle y=8'hA5, y_valid=0100; EMPTY one cycle later.
- Backpressure: load 8'h3C to ch1 with y_ready=0000 -> i_ready=0, y/y_valid stay 8'h3C/0010 for 5 cycles. Set y_ready=1101 (ch1 low) -> still held. Set y_ready[1]=1 -> drained.
- Streaming: 8 consecutive beats 8'h00..8'h07 with s cycling 0,1,2,3, y_ready=1111 -> one beat per cycle, y_valid=0001,0010,0100,1000 repeating, order preserved, i_ready constantly 1.
- Drop: CH_EN=4'b0111, send 300 beats to s=3 -> y_valid stays 0000, drop_cnt saturates at 8'hFF. Then a beat to s=0 is delivered normally.
- Counters (macro defined): deliver 3 beats to ch0 and 70000 beats to ch2 -> ch_cnt slice0=3, slice2=70000 mod 65536=4464, slices 1 and 3=0.
